// File: rtl/dmi_trk_pkg.sv
// dmi_trk_pkg: shared types for the DMI request tracker.
// Holds DMI op/status encodings and the tracker FSM state type.
package dmi_trk_pkg;

  typedef enum logic [1:0] {
    DmiNop   = 2'd0,
    DmiRead  = 2'd1,
    DmiWrite = 2'd2,
    DmiRsvd  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DmiOk   = 2'd0,
    DmiFail = 2'd2,
    DmiBusy = 2'd3
  } dmi_status_e;

  typedef enum logic [2:0] {
    TrkIdle,
    TrkReq,
    TrkWaitRsp,
    TrkResp,
    TrkDrain
  } trk_state_e;

endpackage

// File: rtl/dmi_req_tracker.sv
// dmi_req_tracker: one-outstanding DMI tracker between DTM and dm_csrs.
// Ports: up_req_* (DTM request), up_resp_* (DTM response),
// dn_req_* (to dm_csrs), dn_resp_* (from dm_csrs),
// dmireset_i (clears sticky busy), busy_sticky_o (sticky busy flag).
module dmi_req_tracker
  import dmi_trk_pkg::*;
#(
  parameter int unsigned AddrW         = 7,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             up_req_valid_i,
  output logic             up_req_ready_o,
  input  logic [AddrW-1:0] up_req_addr_i,
  input  logic [1:0]       up_req_op_i,
  input  logic [31:0]      up_req_data_i,
  output logic             up_resp_valid_o,
  input  logic             up_resp_ready_i,
  output logic [31:0]      up_resp_data_o,
  output logic [1:0]       up_resp_status_o,
  output logic             dn_req_valid_o,
  input  logic             dn_req_ready_i,
  output logic [AddrW-1:0] dn_req_addr_o,
  output logic [1:0]       dn_req_op_o,
  output logic [31:0]      dn_req_data_o,
  input  logic             dn_resp_valid_i,
  output logic             dn_resp_ready_o,
  input  logic [31:0]      dn_resp_data_i,
  input  logic [1:0]       dn_resp_status_i,
  input  logic             dmireset_i,
  output logic             busy_sticky_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax  = '1;

  trk_state_e       r_state, w_state_nxt;
  logic [AddrW-1:0] r_addr, w_addr_nxt;
  logic [1:0]       r_op, w_op_nxt;
  logic [31:0]      r_wdata, w_wdata_nxt;
  logic [31:0]      r_rdata, w_rdata_nxt;
  logic [1:0]       r_status, w_status_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_rsp_done, w_rsp_done_nxt;
  logic             r_late_done, w_late_done_nxt;

  // Exactly one of these is set for any incoming request.
  logic w_loc_busy, w_loc_nop, w_loc_rsvd, w_fwd;

  assign w_loc_busy = r_busy;
  assign w_loc_nop  = !r_busy && (up_req_op_i == DmiNop);
  assign w_loc_rsvd = !r_busy && (up_req_op_i == DmiRsvd);
  assign w_fwd      = !r_busy && (up_req_op_i == DmiRead
                                || up_req_op_i == DmiWrite);

  // Ready is masked by reset so it stays low while rst_i is held.
  assign up_req_ready_o   = (r_state == TrkIdle) && !rst_i;
  assign dn_req_valid_o   = (r_state == TrkReq);
  assign up_resp_valid_o  = (r_state == TrkResp)
                         || (r_state == TrkDrain && !r_rsp_done);
  assign dn_resp_ready_o  = (r_state == TrkWaitRsp)
                         || (r_state == TrkDrain && !r_late_done);
  assign dn_req_addr_o    = r_addr;
  assign dn_req_op_o      = r_op;
  assign dn_req_data_o    = r_wdata;
  assign up_resp_data_o   = r_rdata;
  assign up_resp_status_o = r_status;
  assign busy_sticky_o    = r_busy;

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_op_nxt        = r_op;
    w_wdata_nxt     = r_wdata;
    w_rdata_nxt     = r_rdata;
    w_status_nxt    = r_status;
    w_cnt_nxt       = r_cnt;
    w_busy_nxt      = r_busy;
    w_rsp_done_nxt  = r_rsp_done;
    w_late_done_nxt = r_late_done;

    // Applied first so a coincident timeout below re-sets the flag.
    if (dmireset_i) w_busy_nxt = 1'b0;

    unique case (r_state)
      TrkIdle: begin
        if (up_req_valid_i) begin
          w_rdata_nxt = '0;
          w_state_nxt = TrkResp;
          unique case (1'b1)
            w_loc_busy: w_status_nxt = DmiBusy;
            w_loc_nop:  w_status_nxt = DmiOk;
            w_loc_rsvd: w_status_nxt = DmiFail;
            w_fwd: begin
              w_addr_nxt  = up_req_addr_i;
              w_op_nxt    = up_req_op_i;
              w_wdata_nxt = up_req_data_i;
              w_state_nxt = TrkReq;
            end
            default: w_status_nxt = DmiFail;
          endcase
        end
      end
      TrkReq: begin
        if (dn_req_ready_i) begin
          w_cnt_nxt   = '0;
          w_state_nxt = TrkWaitRsp;
        end
      end
      TrkWaitRsp: begin
        if (r_cnt != CntMax) w_cnt_nxt = r_cnt + 1'b1;
        if (dn_resp_valid_i) begin
          w_status_nxt = dn_resp_status_i;
          w_rdata_nxt  = (r_op == DmiRead
                       && dn_resp_status_i == DmiOk)
                       ? dn_resp_data_i : '0;
          w_state_nxt  = TrkResp;
        end else if (r_cnt == CntLast) begin
          w_busy_nxt      = 1'b1;
          w_status_nxt    = DmiBusy;
          w_rdata_nxt     = '0;
          w_rsp_done_nxt  = 1'b0;
          w_late_done_nxt = 1'b0;
          w_state_nxt     = TrkDrain;
        end
      end
      TrkResp: begin
        if (up_resp_ready_i) w_state_nxt = TrkIdle;
      end
      TrkDrain: begin
        // Track busy-response handoff and late dn response
        // independently; leave only once both have happened.
        w_rsp_done_nxt  = r_rsp_done || up_resp_ready_i;
        w_late_done_nxt = r_late_done || dn_resp_valid_i;
        if (w_rsp_done_nxt && w_late_done_nxt)
          w_state_nxt = TrkIdle;
      end
      default: w_state_nxt = TrkIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= TrkIdle;
      r_addr      <= '0;
      r_op        <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_status    <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_rsp_done  <= 1'b0;
      r_late_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_op        <= w_op_nxt;
      r_wdata     <= w_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_status    <= w_status_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= w_busy_nxt;
      r_rsp_done  <= w_rsp_done_nxt;
      r_late_done <= w_late_done_nxt;
    end
  end

endmodule

// File: tb/tb_dmi_req_tracker.sv
// tb_dmi_req_tracker: scoreboard bench for dmi_req_tracker.
// Driver pushes expected responses; monitor and dn responder check.
module tb_dmi_req_tracker;
  import dmi_trk_pkg::*;

  localparam int AW = 7;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          up_req_valid_i;
  logic          up_req_ready_o;
  logic [AW-1:0] up_req_addr_i;
  logic [1:0]    up_req_op_i;
  logic [31:0]   up_req_data_i;
  logic          up_resp_valid_o;
  logic          up_resp_ready_i;
  logic [31:0]   up_resp_data_o;
  logic [1:0]    up_resp_status_o;
  logic          dn_req_valid_o;
  logic          dn_req_ready_i;
  logic [AW-1:0] dn_req_addr_o;
  logic [1:0]    dn_req_op_o;
  logic [31:0]   dn_req_data_o;
  logic          dn_resp_valid_i;
  logic          dn_resp_ready_o;
  logic [31:0]   dn_resp_data_i;
  logic [1:0]    dn_resp_status_i;
  logic          dmireset_i;
  logic          busy_sticky_o;
  logic          drv_dmireset;
  logic          rsp_dmireset;

  assign dmireset_i = drv_dmireset | rsp_dmireset;

  always #5 clk = ~clk;

  dmi_req_tracker #(
    .AddrW(AW),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .up_req_valid_i(up_req_valid_i),
    .up_req_ready_o(up_req_ready_o),
    .up_req_addr_i(up_req_addr_i),
    .up_req_op_i(up_req_op_i),
    .up_req_data_i(up_req_data_i),
    .up_resp_valid_o(up_resp_valid_o),
    .up_resp_ready_i(up_resp_ready_i),
    .up_resp_data_o(up_resp_data_o),
    .up_resp_status_o(up_resp_status_o),
    .dn_req_valid_o(dn_req_valid_o),
    .dn_req_ready_i(dn_req_ready_i),
    .dn_req_addr_o(dn_req_addr_o),
    .dn_req_op_o(dn_req_op_o),
    .dn_req_data_o(dn_req_data_o),
    .dn_resp_valid_i(dn_resp_valid_i),
    .dn_resp_ready_o(dn_resp_ready_o),
    .dn_resp_data_i(dn_resp_data_i),
    .dn_resp_status_i(dn_resp_status_i),
    .dmireset_i(dmireset_i),
    .busy_sticky_o(busy_sticky_o)
  );

  typedef struct {
    logic [1:0]  st;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int            rdy_dly;
    int            k;
    logic [1:0]    st;
    logic [31:0]   rdata;
    int            rst_at;
    bit            hang;
  } fwd_t;

  exp_t exp_q[$];
  fwd_t fwd_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_fwd_issued = 0;
  int   n_fwd_seen = 0;
  bit   model_busy = 1'b0;
  bit   in_wait = 1'b0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
  endtask

  // Reference model: outcome decided from the protocol rules
  // and the responder timing chosen for this request.
  task automatic send(logic [1:0] op, logic [AW-1:0] addr,
                      logic [31:0] wd, int rdy_dly, int k,
                      logic [1:0] st, logic [31:0] rd,
                      int rst_at, bit hang);
    exp_t e;
    fwd_t f;
    bit   fwd;
    bit   push_e;
    int   t;
    fwd = 1'b0;
    push_e = 1'b1;
    e.data = 32'd0;
    if (model_busy) begin
      e.st = 2'd3;
    end else if (op == 2'd0) begin
      e.st = 2'd0;
    end else if (op == 2'd3) begin
      e.st = 2'd2;
    end else begin
      fwd = 1'b1;
      f.op = op; f.addr = addr; f.wdata = wd;
      f.rdy_dly = rdy_dly; f.k = k; f.st = st;
      f.rdata = rd; f.rst_at = rst_at; f.hang = hang;
      if (hang) begin
        push_e = 1'b0;
      end else if (k > TO) begin
        e.st = 2'd3;
        model_busy = 1'b1;
      end else begin
        e.st = st;
        e.data = (op == 2'd1 && st == 2'd0) ? rd : 32'd0;
      end
    end
    if (fwd) begin
      fwd_q.push_back(f);
      n_fwd_issued++;
    end
    if (push_e) exp_q.push_back(e);
    @(posedge clk); #1;
    up_req_valid_i = 1'b1;
    up_req_op_i = op;
    up_req_addr_i = addr;
    up_req_data_i = wd;
    t = 0;
    forever begin
      @(negedge clk);
      if (up_req_ready_o) break;
      t++;
      if (t > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL req_accept: got no ready want ready");
        break;
      end
    end
    @(posedge clk); #1;
    up_req_valid_i = 1'b0;
    @(negedge clk);
    chk("lat_dn_req_valid", dn_req_valid_o, fwd);
    chk("lat_up_resp_valid", up_resp_valid_o, !fwd);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && fwd_q.size() == 0
          && up_req_ready_o) break;
      t++;
      if (t > 400) begin
        n_cmp++; n_bad++;
        $display("FAIL idle_wait: got busy want idle");
        break;
      end
    end
    chk("busy_sticky", busy_sticky_o, model_busy);
  endtask

  task automatic pulse_dmireset();
    wait_idle();
    @(posedge clk); #1;
    drv_dmireset = 1'b1;
    @(posedge clk); #1;
    drv_dmireset = 1'b0;
    model_busy = 1'b0;
    @(negedge clk);
    chk("busy_cleared", busy_sticky_o, 0);
  endtask

  // Upstream monitor: random response back-pressure, pops scoreboard.
  initial begin
    exp_t e;
    up_resp_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      up_resp_ready_i = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (up_resp_valid_o && up_resp_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_resp: got st %0d want none",
                   up_resp_status_o);
        end else begin
          e = exp_q.pop_front();
          chk("resp_status", up_resp_status_o, e.st);
          chk("resp_data", up_resp_data_o, e.data);
        end
      end
    end
  end

  // Downstream responder acting as dm_csrs.
  initial begin
    fwd_t f;
    int   t;
    bit   ok;
    dn_req_ready_i = 1'b0;
    dn_resp_valid_i = 1'b0;
    dn_resp_data_i = 32'd0;
    dn_resp_status_i = 2'd0;
    rsp_dmireset = 1'b0;
    forever begin
      @(negedge clk);
      if (dn_req_valid_o === 1'b1) begin
        n_fwd_seen++;
        if (fwd_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_fwd: got op %0d want none",
                   dn_req_op_o);
          f.op = 2'd1; f.addr = '0; f.wdata = '0;
          f.rdy_dly = 0; f.k = 1; f.st = 2'd0;
          f.rdata = '0; f.rst_at = 0; f.hang = 1'b0;
        end else begin
          f = fwd_q.pop_front();
          chk("fwd_op", dn_req_op_o, f.op);
          chk("fwd_addr", dn_req_addr_o, f.addr);
          chk("fwd_data", dn_req_data_o, f.wdata);
        end
        ok = 1'b1;
        for (int i = 0; i < f.rdy_dly; i++) begin
          @(negedge clk);
          ok &= dn_req_valid_o && dn_req_op_o == f.op
             && dn_req_addr_o == f.addr
             && dn_req_data_o == f.wdata;
        end
        if (f.rdy_dly > 0) chk("fwd_hold", ok, 1);
        dn_req_ready_i = 1'b1;
        @(posedge clk); #1;
        dn_req_ready_i = 1'b0;
        if (f.hang) begin
          in_wait = 1'b1;
        end else begin
          for (int c = 1; c < f.k; c++) begin
            rsp_dmireset = (c == f.rst_at);
            @(posedge clk); #1;
          end
          rsp_dmireset = (f.k == f.rst_at);
          dn_resp_valid_i = 1'b1;
          dn_resp_data_i = f.rdata;
          dn_resp_status_i = f.st;
          t = 0;
          forever begin
            @(negedge clk);
            if (dn_resp_ready_o) break;
            t++;
            if (t > 50) begin
              n_cmp++; n_bad++;
              $display("FAIL dn_resp_ready: got 0 want 1");
              break;
            end
          end
          @(posedge clk); #1;
          dn_resp_valid_i = 1'b0;
          rsp_dmireset = 1'b0;
          if (f.k <= TO) begin
            @(negedge clk);
            chk("lat_resp_fwd", up_resp_valid_o, 1);
          end
        end
      end
    end
  end

  // Driver.
  initial begin
    logic [1:0]    rop;
    logic [AW-1:0] raddr;
    logic [31:0]   rwd;
    logic [31:0]   rrd;
    logic [1:0]    rst_v;
    int            rk;
    int            t;
    rst_i = 1'b1;
    up_req_valid_i = 1'b0;
    up_req_addr_i = '0;
    up_req_op_i = 2'd0;
    up_req_data_i = 32'd0;
    drv_dmireset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_up_req_ready", up_req_ready_o, 0);
    chk("rst_up_resp_valid", up_resp_valid_o, 0);
    chk("rst_dn_req_valid", dn_req_valid_o, 0);
    chk("rst_dn_resp_ready", dn_resp_ready_o, 0);
    chk("rst_busy", busy_sticky_o, 0);
    chk("rst_dn_addr", dn_req_addr_o, 0);
    chk("rst_up_data", up_resp_data_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("idle_ready", up_req_ready_o, 1);

    send(2'd1, 7'h11, 32'd0, 0, 3, 2'd0, 32'h0000_0C82, 0, 0);
    send(2'd2, 7'h10, 32'd1, 5, 2, 2'd0, 32'hDEAD_BEEF, 0, 0);
    send(2'd0, 7'h04, 32'h55, 0, 1, 2'd0, 32'd0, 0, 0);
    send(2'd3, 7'h04, 32'h55, 0, 1, 2'd0, 32'd0, 0, 0);
    send(2'd1, 7'h12, 32'd0, 1, TO, 2'd0, 32'h1234_5678, 0, 0);
    send(2'd1, 7'h13, 32'd0, 0, 1, 2'd2, 32'hFFFF_0000, 0, 0);
    wait_idle();

    send(2'd1, 7'h22, 32'd0, 1, TO + 2, 2'd0, 32'h77, 0, 0);
    wait_idle();
    send(2'd1, 7'h23, 32'd0, 0, 1, 2'd0, 32'h88, 0, 0);
    send(2'd0, 7'h23, 32'd0, 0, 1, 2'd0, 32'h0, 0, 0);
    pulse_dmireset();
    send(2'd1, 7'h05, 32'd0, 0, 2, 2'd0, 32'hA5A5_0001, 0, 0);
    wait_idle();

    send(2'd1, 7'h30, 32'd0, 0, TO + 2, 2'd0, 32'h9, TO, 0);
    wait_idle();
    pulse_dmireset();

    for (int i = 0; i < 90; i++) begin
      rop = 2'($urandom_range(0, 3));
      raddr = AW'($urandom);
      rwd = $urandom;
      rrd = $urandom;
      rst_v = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0;
      if ($urandom_range(0, 9) == 0)
        rk = TO + 1 + $urandom_range(0, 3);
      else
        rk = $urandom_range(1, TO);
      send(rop, raddr, rwd, $urandom_range(0, 3), rk,
           rst_v, rrd, 0, 0);
      if ($urandom_range(0, 7) == 0) pulse_dmireset();
    end
    wait_idle();

    send(2'd1, 7'h40, 32'd0, 0, 1, 2'd0, 32'h1, 0, 1);
    t = 0;
    while (!in_wait && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("reach_wait", in_wait, 1);
    in_wait = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_up_req_ready", up_req_ready_o, 0);
    chk("mid_rst_up_resp_valid", up_resp_valid_o, 0);
    chk("mid_rst_dn_req_valid", dn_req_valid_o, 0);
    chk("mid_rst_dn_resp_ready", dn_resp_ready_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    model_busy = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", up_req_ready_o, 1);
    send(2'd1, 7'h41, 32'd0, 0, 1, 2'd0, 32'hCAFE_F00D, 0, 0);
    wait_idle();

    chk("fwd_count", n_fwd_seen, n_fwd_issued);
    chk("exp_left", exp_q.size(), 0);
    summary();
    $finish;
  end

  initial begin
    #2000000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: got timeout want finish");
    summary();
    $fatal(1, "watchdog expired");
  end

endmodule
